// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Brief    : Multi-cycle ALU with valid/ready handshake. Add, sub and the
//             logic ops finish in one clock; MUL (shift-add) and DIV
//             (restoring) iterate one bit per clock over WIDTH clocks.
//             Reports zero, negative, signed-overflow and divide-by-zero.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             less,
    output logic             ovf,
    output logic             dbz
);

    localparam int         c_msb    = WIDTH - 1;
    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_sub = 3'b001;
    localparam logic [2:0] c_op_mul = 3'b010;
    localparam logic [2:0] c_op_div = 3'b011;
    localparam logic [2:0] c_op_and = 3'b100;
    localparam logic [2:0] c_op_or  = 3'b101;
    localparam logic [2:0] c_op_xor = 3'b110;
    localparam logic [2:0] c_op_xnr = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;

    // Iterative working registers: r_a is multiplicand / quotient shifter,
    // r_b is multiplier shifter / divisor, r_acc is product / remainder.
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   r_out;
    logic               r_zero;
    logic               r_less;
    logic               r_ovf;
    logic               r_dbz;

    logic               w_last;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_alu;
    logic               w_alu_ovf;
    logic [WIDTH-1:0]   w_mul_acc;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_rem_sub;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_q;
    logic [WIDTH-1:0]   w_div_r;
    logic               w_load;
    logic [WIDTH-1:0]   w_res;
    logic               w_res_ovf;
    logic               w_res_dbz;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;
    assign zero      = r_zero;
    assign less      = r_less;
    assign ovf       = r_ovf;
    assign dbz       = r_dbz;

    // The final iteration is the one that moves the counter from 1 to 0.
    assign w_last = (r_cnt == CNT_W'(1));

    // Single-cycle operations and their signed-overflow flag, from live inputs.
    always_comb begin
        w_sum     = a + b;
        w_diff    = a - b;
        w_alu     = '0;
        w_alu_ovf = 1'b0;
        case (op)
            c_op_add: begin
                w_alu     = w_sum;
                w_alu_ovf = (a[c_msb] == b[c_msb]) && (w_sum[c_msb] != a[c_msb]);
            end
            c_op_sub: begin
                w_alu     = w_diff;
                w_alu_ovf = (a[c_msb] == ~b[c_msb]) && (w_diff[c_msb] != a[c_msb]);
            end
            c_op_and: w_alu = a & b;
            c_op_or:  w_alu = a | b;
            c_op_xor: w_alu = a ^ b;
            c_op_xnr: w_alu = ~(a ^ b);
            default:  w_alu = '0;
        endcase
    end

    // One shift-add step and one restoring-division step per clock.
    always_comb begin
        w_mul_acc = r_acc + (r_b[0] ? r_a : '0);
        w_rem_sh  = {r_acc, r_a[c_msb]};
        w_rem_sub = w_rem_sh - {1'b0, r_b};
        w_div_ge  = ~w_rem_sub[WIDTH];
        w_div_q   = {r_a[WIDTH-2:0], w_div_ge};
        w_div_r   = w_div_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    end

    // Select the value and flags that get latched when a result is produced.
    always_comb begin
        w_load    = 1'b0;
        w_res     = '0;
        w_res_ovf = 1'b0;
        w_res_dbz = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (op == c_op_div && b == '0) begin
                        w_load    = 1'b1;
                        w_res     = '1;
                        w_res_dbz = 1'b1;
                    end else if (op != c_op_mul && op != c_op_div) begin
                        w_load    = 1'b1;
                        w_res     = w_alu;
                        w_res_ovf = w_alu_ovf;
                    end
                end
            end
            S_MUL: begin
                if (w_last) begin
                    w_load = 1'b1;
                    w_res  = w_mul_acc;
                end
            end
            S_DIV: begin
                if (w_last) begin
                    w_load = 1'b1;
                    w_res  = w_div_q;
                end
            end
            default: w_load = 1'b0;
        endcase
    end

    // Next-state decode.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (op == c_op_mul)
                        w_state_nx = S_MUL;
                    else if (op == c_op_div && b != '0)
                        w_state_nx = S_DIV;
                    else
                        w_state_nx = S_DONE;
                end
            end
            S_MUL, S_DIV: begin
                if (w_last)
                    w_state_nx = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_acc <= '0;
                        if (op == c_op_mul || (op == c_op_div && b != '0))
                            r_cnt <= CNT_W'(WIDTH);
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_acc;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_DIV: begin
                    r_acc <= w_div_r;
                    r_a   <= w_div_q;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Result and flag registers; loaded once per operation and held in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_zero <= 1'b0;
            r_less <= 1'b0;
            r_ovf  <= 1'b0;
            r_dbz  <= 1'b0;
        end else if (w_load) begin
            r_out  <= w_res;
            r_zero <= (w_res == '0);
            r_less <= w_res[c_msb];
            r_ovf  <= w_res_ovf;
            r_dbz  <= w_res_dbz;
        end
    end

endmodule
`default_nettype wire
